// File: rtl/conv_window_gen.sv
// Sliding KxK window generator over a raster pixel stream using K-1 circular line buffers.
// Define CONV_WINDOW_COORD_EN to add the win_x/win_y top-left coordinate outputs.
module conv_window_gen #(
  parameter int DW    = 8,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int K     = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW-1:0]            in_data,
  input  logic                     in_sof,
  output logic                     win_valid,
  input  logic                     win_ready,
  output logic [K*K*DW-1:0]        win_data,
  output logic                     frame_done,
`ifdef CONV_WINDOW_COORD_EN
  output logic [$clog2(IMG_W)-1:0] win_x,
  output logic [$clog2(IMG_H)-1:0] win_y,
`endif
  output logic                     sof_err
);

  localparam int XW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LBW = (K > 2) ? $clog2(K - 1) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  if (K != 3 && K != 5) begin : g_bad_k
    $error("conv_window_gen: K must be 3 or 5, got %0d", K);
  end
  if (IMG_W < 4 || IMG_W > 1024 || IMG_H < 4 || IMG_H > 1024) begin : g_bad_size
    $error("conv_window_gen: IMG_W/IMG_H must be within 4..1024");
  end

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nxt;

  logic [XW-1:0]     x, px;
  logic [YW-1:0]     y, py;
  logic [LBW-1:0]    wsel, wsel_cur;
  logic              in_acc, restart, process, line_end, frame_end;
  logic              produce, sof_err_set, win_last;
  logic [K*K*DW-1:0] win_nxt;

  logic [DW-1:0] line_buf [K-1][IMG_W];
  logic [DW-1:0] taps     [K][K];
  logic [DW-1:0] taps_nxt [K][K];

  // A start-of-frame pixel is always treated as position (0,0), whether it opens or restarts a frame.
  always_comb begin
    in_ready    = (state == IDLE) || win_ready || !win_valid;
    in_acc      = in_valid && in_ready;
    restart     = in_acc && in_sof;
    process     = restart || (in_acc && (state == ACTIVE));
    px          = restart ? '0 : x;
    py          = restart ? '0 : y;
    wsel_cur    = restart ? '0 : wsel;
    line_end    = (px == X_LAST);
    frame_end   = line_end && (py == Y_LAST);
    produce     = process && (32'(px) >= 32'(K - 1)) && (32'(py) >= 32'(K - 1));
    sof_err_set = restart && (state == ACTIVE) && ((x != '0) || (y != '0));
    state_nxt   = state;
    if (process) begin
      state_nxt = frame_end ? IDLE : ACTIVE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      wsel  <= '0;
    end else begin
      state <= state_nxt;
      if (process) begin
        if (line_end) begin
          x    <= '0;
          y    <= frame_end ? '0 : py + 1'b1;
          wsel <= frame_end ? '0 : wsel_cur + 1'b1;
        end else begin
          x    <= px + 1'b1;
          y    <= py;
          wsel <= wsel_cur;
        end
      end
    end
  end

  // K-1 is a power of two, so buffer rotation is plain LBW-bit wraparound.
  // Buffer wsel_cur holds the oldest line; row r lives in buffer wsel_cur + r.
  always_comb begin
    taps_nxt = taps;
    win_nxt  = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        taps_nxt[r][c] = taps[r][c+1];
      end
      if (r == K - 1) begin
        taps_nxt[r][K-1] = in_data;
      end else begin
        taps_nxt[r][K-1] = line_buf[wsel_cur + LBW'(r)][px];
      end
      for (int c = 0; c < K; c++) begin
        win_nxt[(r*K+c)*DW +: DW] = taps_nxt[r][c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (process) begin
      line_buf[wsel_cur][px] <= in_data;
      taps                   <= taps_nxt;
    end
  end

  // The window register is separate from the taps so an IDLE-state sof pixel cannot disturb a pending window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      win_data  <= '0;
      win_last  <= 1'b0;
      sof_err   <= 1'b0;
    end else begin
      if (produce) begin
        win_valid <= 1'b1;
        win_data  <= win_nxt;
        win_last  <= frame_end;
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
      if (sof_err_set) begin
        sof_err <= 1'b1;
      end
    end
  end

  assign frame_done = win_valid && win_ready && win_last;

`ifdef CONV_WINDOW_COORD_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_x <= '0;
      win_y <= '0;
    end else if (produce) begin
      win_x <= px - XW'(K - 1);
      win_y <= py - YW'(K - 1);
    end
  end
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: port 0 is a 4x4 K=3 instance, port 1 a 6x6 K=5 instance.
// An image-array reference model pushes expected windows; a negedge monitor pops and compares them.
module tb_conv_window_gen;

  typedef struct {
    logic [199:0] data;
    int           wx;
    int           wy;
    bit           last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_in_sof, a_win_valid, a_win_ready, a_frame_done, a_sof_err;
  logic [7:0]  a_in_data;
  logic [71:0] a_win_data;
  logic        b_in_valid, b_in_ready, b_in_sof, b_win_valid, b_win_ready, b_frame_done, b_sof_err;
  logic [7:0]  b_in_data;
  logic [199:0] b_win_data;

`ifdef CONV_WINDOW_COORD_EN
  logic [1:0] a_win_x, a_win_y;
  logic [2:0] b_win_x, b_win_y;
  wire [31:0] ax = 32'(a_win_x);
  wire [31:0] ay = 32'(a_win_y);
  wire [31:0] bx = 32'(b_win_x);
  wire [31:0] by = 32'(b_win_y);
`else
  wire [31:0] ax = 32'd0;
  wire [31:0] ay = 32'd0;
  wire [31:0] bx = 32'd0;
  wire [31:0] by = 32'd0;
`endif

  conv_window_gen #(.DW(8), .IMG_W(4), .IMG_H(4), .K(3)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_sof(a_in_sof),
    .win_valid(a_win_valid), .win_ready(a_win_ready), .win_data(a_win_data),
    .frame_done(a_frame_done),
`ifdef CONV_WINDOW_COORD_EN
    .win_x(a_win_x), .win_y(a_win_y),
`endif
    .sof_err(a_sof_err)
  );

  conv_window_gen #(.DW(8), .IMG_W(6), .IMG_H(6), .K(5)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_sof(b_in_sof),
    .win_valid(b_win_valid), .win_ready(b_win_ready), .win_data(b_win_data),
    .frame_done(b_frame_done),
`ifdef CONV_WINDOW_COORD_EN
    .win_x(b_win_x), .win_y(b_win_y),
`endif
    .sof_err(b_sof_err)
  );

  int checks = 0;
  int errors = 0;

  exp_t         q0[$];
  exp_t         q1[$];
  logic [7:0]   img [2][6][6];
  bit           m_active [2];
  int           m_x [2];
  int           m_y [2];
  bit           m_err [2];
  bit           pend [2];
  logic [199:0] pend_data [2];
  int           win_cnt [2];
  bit           grab_first = 1'b0;
  logic [199:0] first_win = '0;

  int bp_mode     = 0;
  bit stall_armed = 1'b0;
  int stall_left  = 0;
  bit hs;

  task automatic checkOutput(input string name, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int p = 0; p < 2; p++) begin
      m_active[p] = 1'b0;
      m_x[p]      = 0;
      m_y[p]      = 0;
      m_err[p]    = 1'b0;
    end
  endtask

  // Reference: remember every accepted pixel in an image array and cut windows straight out of it.
  task automatic modelAccept(input int p, input logic [7:0] d, input bit sof);
    int   k;
    int   w;
    exp_t e;
    k = (p == 0) ? 3 : 5;
    w = (p == 0) ? 4 : 6;
    if (sof) begin
      if (m_active[p] && (m_x[p] != 0 || m_y[p] != 0)) m_err[p] = 1'b1;
      m_active[p] = 1'b1;
      m_x[p]      = 0;
      m_y[p]      = 0;
    end else if (!m_active[p]) begin
      return;
    end
    img[p][m_y[p]][m_x[p]] = d;
    if (m_x[p] >= k - 1 && m_y[p] >= k - 1) begin
      e.data = '0;
      for (int r = 0; r < k; r++)
        for (int c = 0; c < k; c++)
          e.data[(r*k+c)*8 +: 8] = img[p][m_y[p]-k+1+r][m_x[p]-k+1+c];
      e.wx   = m_x[p] - k + 1;
      e.wy   = m_y[p] - k + 1;
      e.last = (m_x[p] == w - 1) && (m_y[p] == w - 1);
      if (p == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    m_x[p]++;
    if (m_x[p] == w) begin
      m_x[p] = 0;
      m_y[p]++;
      if (m_y[p] == w) begin
        m_y[p]      = 0;
        m_active[p] = 1'b0;
      end
    end
  endtask

  task automatic setIn(input int p, input logic v, input logic [7:0] d, input logic s);
    if (p == 0) begin
      a_in_valid = v; a_in_data = d; a_in_sof = s;
    end else begin
      b_in_valid = v; b_in_data = d; b_in_sof = s;
    end
  endtask

  // Entered and left at posedge+1; the model sees the pixel in the same timestep as the accepting edge.
  task automatic applyStimulus(input int p, input logic [7:0] d, input bit sof);
    bit acc;
    int waited;
    acc    = 1'b0;
    waited = 0;
    setIn(p, 1'b1, d, sof);
    while (!acc && waited < 200) begin
      @(negedge clk);
      acc = (p == 0) ? a_in_ready : b_in_ready;
      @(posedge clk);
      waited++;
    end
    if (acc) begin
      modelAccept(p, d, sof);
    end else begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout port=%0d actual=stalled required=accepted", p);
    end
    #1;
    setIn(p, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sendFrame(input int p, input int offset, input bit rnd, input int maxgap);
    int         w;
    logic [7:0] v;
    w = (p == 0) ? 4 : 6;
    for (int i = 0; i < w * w; i++) begin
      v = rnd ? 8'($urandom) : 8'(offset + i);
      applyStimulus(p, v, i == 0);
      if (maxgap > 0) idleCycles(int'($urandom_range(0, maxgap)));
    end
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || a_win_valid || b_win_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout actual=%0d/%0d pending required=0", q0.size(), q1.size());
    end
  endtask

  task automatic monitorPort(input int p, input logic v, input logic rdy, input logic inrdy,
                             input logic [199:0] d, input logic fd, input int wx, input int wy);
    exp_t e;
    bit   empty;
    if (pend[p]) begin
      checkOutput($sformatf("hold_valid%0d", p), 200'(v), 200'(1));
      checkOutput($sformatf("hold_data%0d", p), d, pend_data[p]);
    end
    if (!m_active[p]) checkOutput($sformatf("in_ready_idle%0d", p), 200'(inrdy), 200'(1));
    else if (v && !rdy) checkOutput($sformatf("in_ready_stall%0d", p), 200'(inrdy), 200'(0));
    if (v && rdy) begin
      win_cnt[p]++;
      if (p == 0 && grab_first) begin
        first_win  = d;
        grab_first = 1'b0;
      end
      empty = (p == 0) ? (q0.size() == 0) : (q1.size() == 0);
      if (empty) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_window port=%0d actual=%0h required=none", p, d);
      end else begin
        if (p == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        checkOutput($sformatf("win_data%0d", p), d, e.data);
        checkOutput($sformatf("frame_done%0d", p), 200'(fd), 200'(e.last));
`ifdef CONV_WINDOW_COORD_EN
        checkOutput($sformatf("win_x%0d", p), 200'(wx), 200'(e.wx));
        checkOutput($sformatf("win_y%0d", p), 200'(wy), 200'(e.wy));
`endif
      end
    end else if (fd) begin
      checkOutput($sformatf("frame_done_spurious%0d", p), 200'(fd), 200'(0));
    end
    pend[p]      = v && !rdy;
    pend_data[p] = d;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      pend[0] = 1'b0;
      pend[1] = 1'b0;
    end else begin
      monitorPort(0, a_win_valid, a_win_ready, a_in_ready, 200'(a_win_data), a_frame_done,
                  int'(ax), int'(ay));
      monitorPort(1, b_win_valid, b_win_ready, b_in_ready, b_win_data, b_frame_done,
                  int'(bx), int'(by));
    end
  end

  // Sink side: mode 0 always ready, mode 1 random, mode 3 stalls port 0 for 5 cycles after its next window.
  initial begin
    a_win_ready = 1'b1;
    b_win_ready = 1'b1;
    forever begin
      @(negedge clk);
      hs = a_win_valid && a_win_ready;
      @(posedge clk);
      #1;
      if (bp_mode == 3 && stall_armed && hs) begin
        stall_armed = 1'b0;
        stall_left  = 5;
      end
      if (bp_mode == 1) begin
        a_win_ready = ($urandom_range(0, 3) != 0);
        b_win_ready = ($urandom_range(0, 3) != 0);
      end else if (stall_left > 0) begin
        a_win_ready = 1'b0;
        b_win_ready = 1'b1;
        stall_left--;
      end else begin
        a_win_ready = 1'b1;
        b_win_ready = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int           base;
    int           ft [9];
    logic [199:0] first_exp;
    ft = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    first_exp = '0;
    for (int i = 0; i < 9; i++) first_exp[i*8 +: 8] = 8'(ft[i]);
    win_cnt[0] = 0;
    win_cnt[1] = 0;
    modelReset();
    rst_n = 1'b0;
    setIn(0, 1'b0, 8'h00, 1'b0);
    setIn(1, 1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] reset values");
    @(negedge clk);
    checkOutput("rst_win_valid", 200'(a_win_valid), 200'(0));
    checkOutput("rst_win_data", 200'(a_win_data), 200'(0));
    checkOutput("rst_frame_done", 200'(a_frame_done), 200'(0));
    checkOutput("rst_sof_err", 200'(a_sof_err), 200'(0));
    checkOutput("rst_in_ready", 200'(a_in_ready), 200'(1));
    checkOutput("rst_b_win_valid", 200'(b_win_valid), 200'(0));
    checkOutput("rst_b_in_ready", 200'(b_in_ready), 200'(1));
    @(posedge clk);
    #1;

    $display("[TB] plain 4x4 frame");
    base = win_cnt[0];
    grab_first = 1'b1;
    sendFrame(0, 0, 1'b0, 0);
    waitDrain();
    checkOutput("plain_count", 200'(win_cnt[0] - base), 200'(4));
    checkOutput("plain_first", first_win, first_exp);
    checkOutput("plain_sof_err", 200'(a_sof_err), 200'(0));

    $display("[TB] sink stall after first window");
    bp_mode = 3;
    stall_armed = 1'b1;
    base = win_cnt[0];
    sendFrame(0, 0, 1'b0, 0);
    waitDrain();
    checkOutput("stall_count", 200'(win_cnt[0] - base), 200'(4));
    bp_mode = 0;

    $display("[TB] leading pixels without sof");
    base = win_cnt[0];
    for (int i = 0; i < 3; i++) applyStimulus(0, 8'hEE, 1'b0);
    sendFrame(0, 0, 1'b0, 0);
    waitDrain();
    checkOutput("nosof_count", 200'(win_cnt[0] - base), 200'(4));

    $display("[TB] early sof at (2,1)");
    base = win_cnt[0];
    for (int i = 0; i < 6; i++) applyStimulus(0, 8'(i), i == 0);
    sendFrame(0, 100, 1'b0, 0);
    waitDrain();
    checkOutput("restart_count", 200'(win_cnt[0] - base), 200'(4));
    checkOutput("restart_sof_err", 200'(a_sof_err), 200'(1));
    idleCycles(3);
    checkOutput("restart_sof_err_held", 200'(a_sof_err), 200'(1));

    $display("[TB] reset mid-frame at (3,2)");
    base = win_cnt[0];
    for (int i = 0; i < 11; i++) applyStimulus(0, 8'(i), i == 0);
    waitDrain();
    checkOutput("partial_count", 200'(win_cnt[0] - base), 200'(1));
    rst_n = 1'b0;
    setIn(0, 1'b1, 8'd11, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    setIn(0, 1'b0, 8'h00, 1'b0);
    modelReset();
    checkOutput("midrst_win_valid", 200'(a_win_valid), 200'(0));
    checkOutput("midrst_frame_done", 200'(a_frame_done), 200'(0));
    checkOutput("midrst_sof_err", 200'(a_sof_err), 200'(0));
    base = win_cnt[0];
    grab_first = 1'b1;
    sendFrame(0, 0, 1'b0, 0);
    waitDrain();
    checkOutput("after_rst_count", 200'(win_cnt[0] - base), 200'(4));
    checkOutput("after_rst_first", first_win, first_exp);

    $display("[TB] random frames with backpressure");
    bp_mode = 1;
    base = win_cnt[0];
    for (int f = 0; f < 3; f++) begin
      repeat ($urandom_range(0, 2)) applyStimulus(0, 8'($urandom), 1'b0);
      sendFrame(0, 0, 1'b1, 2);
    end
    waitDrain();
    checkOutput("random_count", 200'(win_cnt[0] - base), 200'(12));

    $display("[TB] K=5 6x6 frames");
    base = win_cnt[1];
    for (int f = 0; f < 2; f++) sendFrame(1, 0, 1'b1, 1);
    waitDrain();
    checkOutput("k5_count", 200'(win_cnt[1] - base), 200'(8));
    checkOutput("k5_sof_err", 200'(b_sof_err), 200'(m_err[1]));
    checkOutput("final_sof_err", 200'(a_sof_err), 200'(m_err[0]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
